// File: rtl/nco_voice_env_if.sv
// nco_voice_env_if: control and sample bundle of one NCO voice.
// master drives controls, slave returns the sample stream.
interface nco_voice_env_if #(
  parameter int PHASE_W = 32,
  parameter int AMP_W   = 8,
  parameter int ENV_W   = 8,
  parameter int ATTEN_W = 3
);
  logic                      step_in;
  logic [PHASE_W-1:0]        incr_in;
  logic                      incr_we_in;
  logic                      gate_in;
  logic [ENV_W-1:0]          attack_rate_in;
  logic [ENV_W-1:0]          release_rate_in;
  logic [ATTEN_W-1:0]        atten_in;
  logic signed [AMP_W-1:0]   amp_out;
  logic                      valid_out;
  logic                      active_out;

  modport master (
    output step_in, incr_in, incr_we_in, gate_in,
    output attack_rate_in, release_rate_in, atten_in,
    input  amp_out, valid_out, active_out
  );

  modport slave (
    input  step_in, incr_in, incr_we_in, gate_in,
    input  attack_rate_in, release_rate_in, atten_in,
    output amp_out, valid_out, active_out
  );
endinterface

// File: rtl/nco_voice_env.sv
// nco_voice_env: NCO voice with sine table, ASR envelope
// and shift attenuator; 2-cycle step-to-sample latency.
module nco_voice_env #(
  parameter int              PHASE_W      = 32,
  parameter int              LUT_ADDR_W   = 6,
  parameter int              AMP_W        = 8,
  parameter int              ENV_W        = 8,
  parameter int              ATTEN_W      = 3,
  parameter logic [PHASE_W-1:0] DEFAULT_INCR = 32'h1000_0000,
  parameter bit              PHASE_SYNC   = 1'b1
) (
  input logic               clk_in,
  input logic               rst_n_in,
  nco_voice_env_if.slave    bus
);

  localparam int LUT_D = 1 << LUT_ADDR_W;
  localparam int PW    = AMP_W + ENV_W + 1;
  localparam logic [ENV_W:0] ENV_MAX = {1'b0, {ENV_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE, S_ATTACK, S_SUSTAIN, S_RELEASE
  } state_t;

  function automatic logic signed [AMP_W-1:0] lut_val(
    input int k
  );
    real a;
    real x;
    int  r;
    a = real'((1 << (AMP_W - 1)) - 1);
    x = a * $sin(2.0 * 3.14159265358979323846
        * real'(k) / real'(LUT_D));
    if (x >= 0.0) r = $rtoi(x + 0.5);
    else          r = -$rtoi(0.5 - x);
    return r[AMP_W-1:0];
  endfunction

  logic signed [AMP_W-1:0] w_lut [LUT_D];

  for (genvar k = 0; k < LUT_D; k++) begin : g_lut
    localparam logic signed [AMP_W-1:0] V = lut_val(k);
    assign w_lut[k] = V;
  end

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [PHASE_W-1:0]      r_phase;
  logic [PHASE_W-1:0]      r_incr;
  logic [ENV_W-1:0]        r_env;
  logic [ENV_W-1:0]        w_env_nxt;
  logic                    w_phase_clr;
  logic signed [AMP_W-1:0] r_s1_sine;
  logic [ENV_W-1:0]        r_s1_env;
  logic [ATTEN_W-1:0]      r_s1_atten;
  logic                    r_s1_valid;
  logic signed [AMP_W-1:0] r_amp;
  logic                    r_valid;

  logic [LUT_ADDR_W-1:0]   w_idx;
  logic [ENV_W:0]          w_att_full;
  logic                    w_att_sat;
  logic [ENV_W-1:0]        w_att_sum;
  logic                    w_rel_zero;
  logic [ENV_W-1:0]        w_rel_diff;
  logic signed [PW-1:0]    w_sine_x;
  logic signed [PW-1:0]    w_env_x;
  logic signed [PW-1:0]    w_prod;
  logic signed [PW-1:0]    w_shift;
  logic signed [PW-1:0]    w_att;

  assign w_idx      = r_phase[PHASE_W-1 -: LUT_ADDR_W];
  assign w_att_full = {1'b0, r_env}
                    + {1'b0, bus.attack_rate_in};
  assign w_att_sat  = (w_att_full >= ENV_MAX);
  assign w_att_sum  = w_att_sat ? ENV_MAX[ENV_W-1:0]
                                : w_att_full[ENV_W-1:0];
  assign w_rel_zero = (r_env <= bus.release_rate_in);
  assign w_rel_diff = w_rel_zero ? '0
                    : r_env - bus.release_rate_in;

  assign w_sine_x = {{(ENV_W+1){r_s1_sine[AMP_W-1]}},
                     r_s1_sine};
  assign w_env_x  = {{AMP_W{1'b0}}, 1'b0, r_s1_env};
  assign w_prod   = w_sine_x * w_env_x;
  assign w_shift  = w_prod >>> ENV_W;
  assign w_att    = w_shift >>> r_s1_atten;

  assign bus.amp_out    = r_amp;
  assign bus.valid_out  = r_valid;
  assign bus.active_out = (r_state != S_IDLE);

  // Envelope state register, advanced only on sample steps
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)        r_state <= S_IDLE;
    else if (bus.step_in) r_state <= w_state_nxt;
  end

  // Envelope next-state decode from gate and level limits
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (bus.gate_in) w_state_nxt = S_ATTACK;
      S_ATTACK:
        if (!bus.gate_in)  w_state_nxt = S_RELEASE;
        else if (w_att_sat) w_state_nxt = S_SUSTAIN;
      S_SUSTAIN:
        if (!bus.gate_in) w_state_nxt = S_RELEASE;
      S_RELEASE:
        if (bus.gate_in)     w_state_nxt = S_ATTACK;
        else if (w_rel_zero) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Envelope level and phase-sync actions per state
  always_comb begin
    w_env_nxt   = r_env;
    w_phase_clr = 1'b0;
    unique case (r_state)
      S_IDLE:
        w_phase_clr = bus.gate_in & PHASE_SYNC;
      S_ATTACK:
        if (bus.gate_in) w_env_nxt = w_att_sum;
      S_RELEASE:
        if (!bus.gate_in) w_env_nxt = w_rel_diff;
      default: w_env_nxt = r_env;
    endcase
  end

  // Phase accumulator, increment register and envelope level
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_phase <= '0;
      r_incr  <= DEFAULT_INCR;
      r_env   <= '0;
    end else begin
      if (bus.incr_we_in) r_incr <= bus.incr_in;
      if (bus.step_in) begin
        r_phase <= w_phase_clr ? '0 : r_phase + r_incr;
        r_env   <= w_env_nxt;
      end
    end
  end

  // Two-stage sample pipeline: table/env capture, then scale
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_s1_sine  <= '0;
      r_s1_env   <= '0;
      r_s1_atten <= '0;
      r_s1_valid <= 1'b0;
      r_amp      <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_s1_valid <= bus.step_in;
      if (bus.step_in) begin
        r_s1_sine  <= w_lut[w_idx];
        r_s1_env   <= r_env;
        r_s1_atten <= bus.atten_in;
      end
      r_valid <= r_s1_valid;
      if (r_s1_valid) r_amp <= w_att[AMP_W-1:0];
    end
  end

endmodule

// File: tb/tb_nco_voice_env.sv
// tb_nco_voice_env: directed table of single steps plus
// hand sequences for increment load, wrap, burst and reset.
module tb_nco_voice_env;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nco_voice_env_if intf ();

  nco_voice_env dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (intf)
  );

  typedef struct {
    logic        gate;
    logic [2:0]  atten;
    logic        we;
    logic [31:0] incr;
    int          amp;
    logic        act;
    int          env;
    logic [31:0] ph;
  } vec_t;

  vec_t tv[22];

  task automatic check(input string nm, input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic run_step(input logic g,
                          input logic [2:0] at,
                          input logic we,
                          input logic [31:0] inc);
    @(negedge clk);
    intf.gate_in    = g;
    intf.atten_in   = at;
    intf.incr_we_in = we;
    intf.incr_in    = inc;
    intf.step_in    = 1'b1;
    @(negedge clk);
    intf.step_in    = 1'b0;
    intf.incr_we_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_incr(input logic [31:0] inc);
    @(negedge clk);
    intf.incr_we_in = 1'b1;
    intf.incr_in    = inc;
    @(negedge clk);
    intf.incr_we_in = 1'b0;
  endtask

  initial begin
    int nval;
    intf.step_in         = 1'b0;
    intf.incr_in         = '0;
    intf.incr_we_in      = 1'b0;
    intf.gate_in         = 1'b0;
    intf.attack_rate_in  = 8'd64;
    intf.release_rate_in = 8'd100;
    intf.atten_in        = '0;

    //      gate  at   we   incr          amp  act env ph
    tv[0]  = '{0, 3'd0, 0, 32'h0,         0,   0, 0,   32'h1000_0000};
    tv[1]  = '{0, 3'd0, 0, 32'h0,         0,   0, 0,   32'h2000_0000};
    tv[2]  = '{0, 3'd0, 0, 32'h0,         0,   0, 0,   32'h3000_0000};
    tv[3]  = '{1, 3'd0, 0, 32'h0,         0,   1, 0,   32'h0000_0000};
    tv[4]  = '{1, 3'd0, 0, 32'h0,         0,   1, 64,  32'h1000_0000};
    tv[5]  = '{1, 3'd0, 0, 32'h0,         12,  1, 128, 32'h2000_0000};
    tv[6]  = '{1, 3'd0, 0, 32'h0,         45,  1, 192, 32'h3000_0000};
    tv[7]  = '{1, 3'd0, 1, 32'h0,         87,  1, 255, 32'h4000_0000};
    tv[8]  = '{1, 3'd0, 0, 32'h0,         126, 1, 255, 32'h4000_0000};
    tv[9]  = '{1, 3'd3, 1, 32'h8000_0000, 15,  1, 255, 32'h4000_0000};
    tv[10] = '{1, 3'd0, 1, 32'h0,         126, 1, 255, 32'hC000_0000};
    tv[11] = '{1, 3'd0, 0, 32'h0,         -127,1, 255, 32'hC000_0000};
    tv[12] = '{1, 3'd3, 0, 32'h0,         -16, 1, 255, 32'hC000_0000};
    tv[13] = '{0, 3'd0, 0, 32'h0,         -127,1, 255, 32'hC000_0000};
    tv[14] = '{0, 3'd0, 0, 32'h0,         -127,1, 155, 32'hC000_0000};
    tv[15] = '{1, 3'd0, 0, 32'h0,         -77, 1, 155, 32'hC000_0000};
    tv[16] = '{1, 3'd0, 0, 32'h0,         -77, 1, 219, 32'hC000_0000};
    tv[17] = '{0, 3'd0, 0, 32'h0,         -109,1, 219, 32'hC000_0000};
    tv[18] = '{0, 3'd0, 0, 32'h0,         -109,1, 119, 32'hC000_0000};
    tv[19] = '{0, 3'd0, 0, 32'h0,         -60, 1, 19,  32'hC000_0000};
    tv[20] = '{0, 3'd0, 0, 32'h0,         -10, 0, 0,   32'hC000_0000};
    tv[21] = '{0, 3'd0, 0, 32'h0,         0,   0, 0,   32'hC000_0000};

    repeat (3) @(negedge clk);
    check("rst_amp", int'($signed(intf.amp_out)), 0);
    check("rst_valid", int'(intf.valid_out), 0);
    check("rst_active", int'(intf.active_out), 0);
    check("rst_phase", int'(dut.r_phase), 0);
    check("rst_env", int'(dut.r_env), 0);
    check("rst_incr", int'(dut.r_incr), 32'h1000_0000);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      run_step(tv[i].gate, tv[i].atten, tv[i].we, tv[i].incr);
      check($sformatf("v%0d_amp", i),
            int'($signed(intf.amp_out)), tv[i].amp);
      check($sformatf("v%0d_valid", i),
            int'(intf.valid_out), 1);
      check($sformatf("v%0d_active", i),
            int'(intf.active_out), int'(tv[i].act));
      check($sformatf("v%0d_env", i),
            int'(dut.r_env), tv[i].env);
      check($sformatf("v%0d_phase", i),
            int'(dut.r_phase), int'(tv[i].ph));
      @(negedge clk);
      check($sformatf("v%0d_vlow", i),
            int'(intf.valid_out), 0);
    end

    load_incr(32'h1000_0000);
    check("ld_incr", int'(dut.r_incr), 32'h1000_0000);
    check("ld_phase", int'(dut.r_phase), 32'hC000_0000);
    run_step(1'b0, 3'd0, 1'b1, 32'h0800_0000);
    check("we_old", int'(dut.r_phase), 32'hD000_0000);
    check("we_new_reg", int'(dut.r_incr), 32'h0800_0000);
    run_step(1'b0, 3'd0, 1'b0, 32'h0);
    check("we_new", int'(dut.r_phase), 32'hD800_0000);
    load_incr(32'h1800_0000);
    run_step(1'b0, 3'd0, 1'b0, 32'h0);
    check("pre_wrap", int'(dut.r_phase), 32'hF000_0000);
    load_incr(32'h1000_0000);
    run_step(1'b0, 3'd0, 1'b0, 32'h0);
    check("wrap", int'(dut.r_phase), 0);

    nval = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (intf.valid_out) nval++;
      intf.step_in = (i < 10);
    end
    check("burst_valids", nval, 10);

    intf.gate_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      intf.step_in = 1'b1;
    end
    check("pre_rst_amp", int'($signed(intf.amp_out)), 45);
    check("pre_rst_valid", int'(intf.valid_out), 1);
    check("pre_rst_active", int'(intf.active_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_amp", int'($signed(intf.amp_out)), 0);
    check("arst_valid", int'(intf.valid_out), 0);
    check("arst_active", int'(intf.active_out), 0);
    @(negedge clk);
    intf.step_in = 1'b0;
    intf.gate_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rel_phase", int'(dut.r_phase), 0);
    check("rel_incr", int'(dut.r_incr), 32'h1000_0000);
    run_step(1'b0, 3'd0, 1'b0, 32'h0);
    check("post_phase", int'(dut.r_phase), 32'h1000_0000);
    check("post_amp", int'($signed(intf.amp_out)), 0);
    check("post_valid", int'(intf.valid_out), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
